cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one backing-memory channel between icache line refills (read) and dcache line refills/writebacks.
//  Sits between the MIPS150 cache pair and the memory controller.
//  Two-way round-robin grant; one line transaction (command + BEATS data beats) in flight at a time.
//  Read beats are steered back to the owning cache.
// PARAMETERS
//  ADDR_W   28   line address width (byte address >> log2(line bytes))
//  DATA_W   128  beat width, bits
//  BEATS    4    data beats per line transaction; power of 2, >= 1
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous, active-high reset
//  ic_req_valid    in   1       icache requests a line read
//  ic_req_addr     in   ADDR_W  icache line address; stable while ic_req_valid && !ic_req_ready
//  ic_req_ready    out  1       icache request accepted this cycle
//  ic_rdata        out  DATA_W  read beat to icache
//  ic_rdata_valid  out  1       ic_rdata valid this cycle
//  dc_req_valid    in   1       dcache requests a line transaction
//  dc_req_we       in   1       1 = writeback, 0 = refill
//  dc_req_addr     in   ADDR_W  dcache line address; stable until accepted
//  dc_req_ready    out  1       dcache request accepted this cycle
//  dc_wdata        in   DATA_W  writeback beat
//  dc_wdata_valid  in   1       dc_wdata valid
//  dc_wdata_ready  out  1       writeback beat consumed
//  dc_rdata        out  DATA_W  read beat to dcache
//  dc_rdata_valid  out  1       dc_rdata valid this cycle
//  mem_cmd_valid   out  1       command to memory valid
//  mem_cmd_ready   in   1       memory accepts command
//  mem_cmd_we      out  1       command is write
//  mem_cmd_addr    out  ADDR_W  command line address
//  mem_wdata       out  DATA_W  write beat to memory
//  mem_wdata_valid out  1       write beat valid
//  mem_wdata_ready in   1       memory accepts write beat
//  mem_rdata       in   DATA_W  read beat from memory
//  mem_rdata_valid in   1       read beat valid; no backpressure
//  busy            out  1       transaction in progress (state != IDLE)
//  err             out  1       sticky: mem_rdata_valid seen outside RDATA; cleared only by rst
// BEHAVIOUR
//  Reset:
//   - state=IDLE, beat_cnt=0, owner=IC, last_grant=IC, err=0.
//   - All outputs are 0, except mem_cmd_addr/mem_cmd_we = 0 and data buses, which are don't-care.
//  FSM: IDLE -> CMD -> (WDATA | RDATA) -> IDLE.
//  IDLE:
//   - One valid requester is granted. If both are valid, the requester != last_grant wins, so dcache wins the first tie after reset.
//   - Granted *_req_ready=1 combinationally in the same cycle; the other ready is 0.
//   - On grant: latch addr into mem_cmd_addr. Latch we (icache forces 0). owner<=grantee; last_grant<=grantee; ->CMD.
//   - A requester deasserting valid before ready: no grant, no state change.
//  CMD:
//   - mem_cmd_valid=1 (decoded from the state register, so it rises 1 cycle after accept).
//   - Hold addr/we until mem_cmd_ready; then ->WDATA if we, else ->RDATA.
//   - beat_cnt=0.
//  WDATA (owner is always DC):
//   - Pass-through: mem_wdata=dc_wdata, mem_wdata_valid=dc_wdata_valid, dc_wdata_ready=mem_wdata_ready.
//   - beat_cnt++ on each valid&&ready; on handshake with beat_cnt==BEATS-1 ->IDLE.
//   - dc_wdata_ready=0 in every other state.
//  RDATA:
//   - *_rdata=mem_rdata to both caches.
//   - ic_rdata_valid=mem_rdata_valid&&owner==IC; dc_rdata_valid=mem_rdata_valid&&owner==DC.
//   - Zero added latency. beat_cnt++ per valid; last beat ->IDLE.
//  Throughput:
//   - New grant possible in the IDLE cycle right after the last beat, giving a 1 idle cycle bubble between transactions.
//   - Worst-case wait for a requester: one other transaction (no starvation).
//  mem_rdata_valid outside RDATA: dropped (no *_rdata_valid), err<=1.
//  beat_cnt: $clog2(BEATS) bits, wraps to 0 on the terminating beat. BEATS=1 uses a 1-bit counter, terminating on the first beat.
//  rst mid-transaction:
//   - Returns to reset state next edge; the partial transaction is abandoned.
//   - The memory controller shares rst and must also abandon it.
// STRUCTURE
//  cache_mem_defs.vh: state encodings (IDLE/CMD/WDATA/RDATA), owner encoding (IC=0, DC=1).
//  Sub-module rr_arbiter2: 2-way round-robin (req[1:0], last, advance -> grant[1:0], registered last).
//  Remainder: FSM, beat counter, address/we latch, steering muxes, err flag.
// TESTING
//  ic read only, addr=0x0000123: mem_cmd_valid at T+1, addr 0x0000123, we=0; 4 rdata beats -> 4 ic_rdata_valid, 0 dc_rdata_valid; busy drops after beat 4.
//  Both valid same cycle right after rst: dc granted first (dc_req_ready=1, ic_req_ready=0). ic granted next, then dc again if still requesting.
//  dc writeback, mem_wdata_ready toggling 1,0,1,0...: exactly 4 beats forwarded in order; dc_wdata_ready mirrors mem_wdata_ready; back to IDLE after 4th.
//  mem_cmd_ready held 0 for 5 cycles: mem_cmd_valid/addr/we stable all 5 cycles; no ready issued to either cache.
//  Spurious mem_rdata_valid in IDLE: no *_rdata_valid; err=1 and stays 1 until rst.
//  rst asserted during beat 2 of an ic read: next cycle state IDLE, busy=0, err=0; a fresh dc request is granted immediately after rst falls.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM states, owner encoding and
// the beat-counter width helper.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // A single-beat line still gets a 1-bit counter so the datapath stays uniform.
    function automatic int cntWidth(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is chosen; the winner is remembered only when advance is asserted.
import cache_mem_arbiter_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b0;
        else if (advance && (grant != 2'b00))
            last <= grant[1];
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory channel between icache refills and dcache refills/writebacks;
// one line transaction in flight, read beats steered to the owning cache.
import cache_mem_arbiter_pkg::*;

module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rdata_valid,
    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rdata_valid,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = cntWidth(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  beatCnt;
    logic [1:0]        grant;
    logic              inIdle;
    logic              wrBeat;
    logic              rdBeat;

    // Requests are only visible to the arbiter while idle and out of reset.
    assign inIdle = (state == IDLE) && !rst;

    rr_arbiter2 uArb (
        .clk     (clk),
        .rst     (rst),
        .req     ({dc_req_valid, ic_req_valid} & {2{inIdle}}),
        .advance (inIdle),
        .grant   (grant)
    );

    assign ic_req_ready    = grant[0];
    assign dc_req_ready    = grant[1];
    assign mem_cmd_valid   = (state == CMD);
    assign busy            = (state != IDLE);

    assign mem_wdata       = dc_wdata;
    assign mem_wdata_valid = (state == WDATA) && dc_wdata_valid;
    assign dc_wdata_ready  = (state == WDATA) && mem_wdata_ready;
    assign wrBeat          = (state == WDATA) && dc_wdata_valid && mem_wdata_ready;

    assign ic_rdata        = mem_rdata;
    assign dc_rdata        = mem_rdata;
    assign rdBeat          = (state == RDATA) && mem_rdata_valid;
    assign ic_rdata_valid  = rdBeat && (owner == OWN_IC);
    assign dc_rdata_valid  = rdBeat && (owner == OWN_DC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_IC;
            beatCnt      <= '0;
            mem_cmd_addr <= '0;
            mem_cmd_we   <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Read data with no read in progress has nowhere to go.
            if (mem_rdata_valid && (state != RDATA))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        mem_cmd_addr <= grant[1] ? dc_req_addr : ic_req_addr;
                        mem_cmd_we   <= grant[1] & dc_req_we;
                        owner        <= grant[1] ? OWN_DC : OWN_IC;
                        beatCnt      <= '0;
                        state        <= CMD;
                    end
                end
                CMD: begin
                    beatCnt <= '0;
                    if (mem_cmd_ready)
                        state <= mem_cmd_we ? WDATA : RDATA;
                end
                WDATA, RDATA: begin
                    if (wrBeat || rdBeat) begin
                        if (beatCnt == LAST_BEAT) begin
                            beatCnt <= '0;
                            state   <= IDLE;
                        end else begin
                            beatCnt <= beatCnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: grant order, read steering,
// writeback pass-through, command stall, spurious read data and mid-line reset.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ic_req_valid = 1'b0;
    logic [ADDR_W-1:0] ic_req_addr = '0;
    logic              ic_req_ready;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rdata_valid;
    logic              dc_req_valid = 1'b0;
    logic              dc_req_we = 1'b0;
    logic [ADDR_W-1:0] dc_req_addr = '0;
    logic              dc_req_ready;
    logic [DATA_W-1:0] dc_wdata = '0;
    logic              dc_wdata_valid = 1'b0;
    logic              dc_wdata_ready;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rdata_valid;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready = 1'b0;
    logic              mem_cmd_we;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rdata_valid = 1'b0;
    logic              busy;
    logic              err;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rdata(ic_rdata), .ic_rdata_valid(ic_rdata_valid),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_valid(dc_wdata_valid),
        .dc_wdata_ready(dc_wdata_ready), .dc_rdata(dc_rdata), .dc_rdata_valid(dc_rdata_valid),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .busy(busy), .err(err)
    );

    // Every step leaves the bench 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives a read from CMD through all beats; counts beats seen per cache.
    task automatic runRead(input int base, output int icCnt, output int dcCnt, output int dataErr);
        icCnt = 0; dcCnt = 0; dataErr = 0;
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = DATA_W'(base + b);
            #1;
            if (ic_rdata_valid) icCnt++;
            if (dc_rdata_valid) dcCnt++;
            if (ic_rdata !== DATA_W'(base + b) || dc_rdata !== DATA_W'(base + b)) dataErr++;
            step();
        end
        mem_rdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", busy); end
        nChecks++; if (err !== 1'b0) begin nFail++; $display("FAIL reset_err got %b want 0", err); end
        nChecks++; if (mem_cmd_valid !== 1'b0) begin nFail++; $display("FAIL reset_cmd_valid got %b want 0", mem_cmd_valid); end
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin nFail++; $display("FAIL reset_readys got %b want 00", {ic_req_ready, dc_req_ready}); end
        nChecks++; if (mem_cmd_addr !== '0 || mem_cmd_we !== 1'b0) begin nFail++; $display("FAIL reset_addr_we got %h/%b want 0/0", mem_cmd_addr, mem_cmd_we); end
        step();
    endtask

    task automatic test_ic_read();
        int ic, dc, de;
        ic_req_valid = 1'b1;
        ic_req_addr  = 28'h0000123;
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin nFail++; $display("FAIL icrd_grant got %b want 10", {ic_req_ready, dc_req_ready}); end
        step();
        ic_req_valid = 1'b0;
        #1;
        nChecks++; if ({mem_cmd_valid, mem_cmd_we, busy} !== 3'b101) begin nFail++; $display("FAIL icrd_cmd got %b want 101", {mem_cmd_valid, mem_cmd_we, busy}); end
        nChecks++; if (mem_cmd_addr !== 28'h0000123) begin nFail++; $display("FAIL icrd_addr got %h want 0000123", mem_cmd_addr); end
        runRead(32'h500, ic, dc, de);
        nChecks++; if (ic !== 4 || dc !== 0) begin nFail++; $display("FAIL icrd_beats got ic=%0d dc=%0d want 4/0", ic, dc); end
        nChecks++; if (de !== 0) begin nFail++; $display("FAIL icrd_data got %0d bad beats want 0", de); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL icrd_done busy got %b want 0", busy); end
    endtask

    task automatic test_tie();
        int ic, dc, de;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ic_req_valid = 1'b1; ic_req_addr = 28'h00000AA;
        dc_req_valid = 1'b1; dc_req_addr = 28'h00000BB; dc_req_we = 1'b0;
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin nFail++; $display("FAIL tie_first got ic/dc %b want 01", {ic_req_ready, dc_req_ready}); end
        step();
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin nFail++; $display("FAIL tie_cmd_readys got %b want 00", {ic_req_ready, dc_req_ready}); end
        nChecks++; if (mem_cmd_addr !== 28'h00000BB) begin nFail++; $display("FAIL tie_dc_addr got %h want 00000BB", mem_cmd_addr); end
        runRead(32'h600, ic, dc, de);
        nChecks++; if (ic !== 0 || dc !== 4) begin nFail++; $display("FAIL tie_dc_beats got ic=%0d dc=%0d want 0/4", ic, dc); end
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin nFail++; $display("FAIL tie_second got ic/dc %b want 10", {ic_req_ready, dc_req_ready}); end
        step();
        runRead(32'h700, ic, dc, de);
        nChecks++; if (ic !== 4 || dc !== 0) begin nFail++; $display("FAIL tie_ic_beats got ic=%0d dc=%0d want 4/0", ic, dc); end
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin nFail++; $display("FAIL tie_third got ic/dc %b want 01", {ic_req_ready, dc_req_ready}); end
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        step();
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL tie_withdraw busy got %b want 0", busy); end
    endtask

    task automatic test_writeback();
        int sent = 0;
        logic hs;
        mem_wdata_ready = 1'b1;
        #1;
        nChecks++; if (dc_wdata_ready !== 1'b0) begin nFail++; $display("FAIL wb_idle_wready got %b want 0", dc_wdata_ready); end
        dc_req_valid = 1'b1; dc_req_we = 1'b1; dc_req_addr = 28'h0000456;
        step();
        dc_req_valid = 1'b0; dc_req_we = 1'b0;
        #1;
        nChecks++; if ({mem_cmd_valid, mem_cmd_we} !== 2'b11 || mem_cmd_addr !== 28'h0000456) begin nFail++; $display("FAIL wb_cmd got v/we %b addr %h want 11/0000456", {mem_cmd_valid, mem_cmd_we}, mem_cmd_addr); end
        nChecks++; if (dc_wdata_ready !== 1'b0) begin nFail++; $display("FAIL wb_cmd_wready got %b want 0", dc_wdata_ready); end
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 20 && sent < BEATS; i++) begin
            mem_wdata_ready = (i % 2 == 0);
            dc_wdata_valid  = 1'b1;
            dc_wdata        = DATA_W'(32'h100 + sent);
            #1;
            nChecks++; if (dc_wdata_ready !== mem_wdata_ready) begin nFail++; $display("FAIL wb_mirror cyc %0d got %b want %b", i, dc_wdata_ready, mem_wdata_ready); end
            nChecks++; if (mem_wdata_valid !== 1'b1 || mem_wdata !== DATA_W'(32'h100 + sent)) begin nFail++; $display("FAIL wb_fwd cyc %0d got v=%b d=%h want 1/%h", i, mem_wdata_valid, mem_wdata, 32'h100 + sent); end
            hs = mem_wdata_valid && mem_wdata_ready;
            step();
            if (hs) sent++;
        end
        dc_wdata_valid = 1'b0; mem_wdata_ready = 1'b0;
        nChecks++; if (sent !== BEATS) begin nFail++; $display("FAIL wb_count got %0d want %0d", sent, BEATS); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL wb_done busy got %b want 0", busy); end
    endtask

    task automatic test_cmd_stall();
        int ic, dc, de;
        ic_req_valid = 1'b1; ic_req_addr = 28'h0000777;
        step();
        dc_req_valid = 1'b1; dc_req_addr = 28'h0000888; dc_req_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            nChecks++; if ({mem_cmd_valid, mem_cmd_we} !== 2'b10 || mem_cmd_addr !== 28'h0000777) begin nFail++; $display("FAIL stall_cmd cyc %0d got v/we %b addr %h want 10/0000777", i, {mem_cmd_valid, mem_cmd_we}, mem_cmd_addr); end
            nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin nFail++; $display("FAIL stall_readys cyc %0d got %b want 00", i, {ic_req_ready, dc_req_ready}); end
            step();
        end
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_we = 1'b0;
        runRead(32'h800, ic, dc, de);
        nChecks++; if (ic !== 4 || dc !== 0 || busy !== 1'b0) begin nFail++; $display("FAIL stall_finish got ic=%0d dc=%0d busy=%b want 4/0/0", ic, dc, busy); end
    endtask

    task automatic test_spurious();
        mem_rdata_valid = 1'b1;
        mem_rdata = DATA_W'(32'hDEAD);
        #1;
        nChecks++; if ({ic_rdata_valid, dc_rdata_valid} !== 2'b00) begin nFail++; $display("FAIL spur_drop got %b want 00", {ic_rdata_valid, dc_rdata_valid}); end
        step();
        mem_rdata_valid = 1'b0;
        nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL spur_err got %b want 1", err); end
        step(); step(); step();
        nChecks++; if (err !== 1'b1) begin nFail++; $display("FAIL spur_sticky got %b want 1", err); end
    endtask

    task automatic test_rst_mid();
        ic_req_valid = 1'b1; ic_req_addr = 28'h0000321;
        step();
        ic_req_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = DATA_W'(32'h900);
        step();
        mem_rdata = DATA_W'(32'h901);
        rst = 1'b1;
        step();
        mem_rdata_valid = 1'b0;
        nChecks++; if ({busy, err, mem_cmd_valid} !== 3'b000) begin nFail++; $display("FAIL rstmid_state got busy/err/cmd %b want 000", {busy, err, mem_cmd_valid}); end
        rst = 1'b0;
        dc_req_valid = 1'b1; dc_req_addr = 28'h0000ABC; dc_req_we = 1'b0;
        #1;
        nChecks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin nFail++; $display("FAIL rstmid_grant got %b want 01", {ic_req_ready, dc_req_ready}); end
        step();
        dc_req_valid = 1'b0;
        #1;
        nChecks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 28'h0000ABC) begin nFail++; $display("FAIL rstmid_cmd got v=%b addr %h want 1/0000ABC", mem_cmd_valid, mem_cmd_addr); end
        nChecks++; if (err !== 1'b0) begin nFail++; $display("FAIL rstmid_err got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_tie();
        test_writeback();
        test_cmd_stall();
        test_spurious();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
